id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. It sits directly downstream of the main control decoder and register file. It captures the decoded control bundle plus operands at each rising edge and feeds the EX stage. It also inserts bubbles on load-use hazards or branch/jump flushes, and raises a stall request that freezes the PC and the IF/ID register.

## Interface
Parameters:
- DW, 32, datapath width (operands, PC+4, immediate)
- RW, 5, register-specifier width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_ctrl  in  10  {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite} from the control decoder
- id_op  in  6  opcode of the ID instruction
- id_pc4, id_rs_data, id_rt_data, id_imm  in  DW  PC+4, register-file reads, sign-extended immediate
- id_rs, id_rt, id_rd  in  RW  register specifiers
- flush  in  1  branch taken or jump resolved; squash the ID instruction
- ex_ctrl  out  10  registered control bundle, same field order
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DW  registered data
- ex_rs, ex_rt, ex_rd  out  RW  registered specifiers
- stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- Hazard: stall = !flush && ex_ctrl.MemRead && ex_rt != 0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt)).
- uses_rt is 1 for opcodes R-format (0), beq (4), sw (43) and 0 otherwise (lw 35, addi 8, ori 13, j 2).
- Per edge, priority flush > stall > load:
  - flush or stall: ex_ctrl <= 0 (bubble); data/specifier outputs <= 0.
  - else: all ex_* <= id_*.
- Sanitising: any X/Z bit in id_ctrl loads as 0. The decoder emits don't-cares for some opcodes, and EX must never see X.
- There is no internal state beyond the output registers, plus the counter under Configuration.

## Timing
- Reset (async assert, sync release on next edge): every ex_* output is 0, the counter is 0, and stall is 0 because ex_ctrl.MemRead = 0.
- Latency: 1 cycle from id_* to ex_*.
- A load-use hazard yields exactly one bubble. In the cycle after the bubble, ex_ctrl.MemRead = 0, so stall drops and the held ID instruction loads.
- Back-to-back lw followed by a dependent lw: each produces its own single bubble.
- flush and hazard in the same cycle: stall = 0 and a bubble is inserted, so the squashed instruction is never held.
- Reset mid-stall: outputs clear immediately and stall deasserts combinationally.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - adds output bubble_cnt [31:0], which increments on every edge where stall && !flush;
  - the counter wraps at 2^32−1 → 0 and resets to 0.
- ID_EX_PERF_CNT_EN undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - opcode constants R_FORMAT=0, J=2, BEQ=4, ADDI=8, ORI=13, LW=35, SW=43;
  - ctrl_t packed struct in the field order above;
  - CTRL_BUBBLE = '0.
- One sub-module, hazard_detect: purely combinational, computes stall from ex_ctrl.MemRead, ex_rt, id_rs, id_rt, id_op and flush.

## Test plan
- Reset with rst_n=0 mid-run, all id_* nonzero → every ex_* = 0 asynchronously, stall = 0.
- Load-use stall:
  - stimulus: lw $8 in EX (ex_rt=8, MemRead=1); ID is R-format with id_rs=8;
  - response: stall=1 for one cycle, and the next ex_ctrl = 0;
  - following cycle: stall=0 and the R-format loads.
- Opcode/specifier filtering on the same lw in EX:
  - ID addi with id_rt=8, id_rs=3 → stall=0;
  - ID sw with id_rt=8 → stall=1;
  - ex_rt=0 with id_rs=0 → stall=0.
- Flush during a hazard: flush=1 with the hazard condition true → stall=0, and the next ex_ctrl = 0.
- X sanitising: id_op=2 (j) with RegDst/MemtoReg = X → ex_ctrl.Jump=1 and all X fields load as 0.
- ID_EX_PERF_CNT_EN:
  - 3 load-use hazards, one of them coincident with flush → bubble_cnt=2;
  - counter preloaded to 0xFFFF_FFFF plus one hazard → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, the decoded control bundle and helpers.
package mips_pkg;

  localparam int CTRL_W = 10;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] ADDI     = 6'd8;
  localparam logic [5:0] ORI      = 6'd13;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       memto_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Only these formats actually read rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == R_FORMAT) || (op == BEQ) || (op == SW);
  endfunction

  // Decoder don't-cares (X/Z) must reach EX as a clean 0.
  function automatic ctrl_t sanitize_ctrl(input logic [CTRL_W-1:0] c);
    logic [CTRL_W-1:0] r;
    for (int i = 0; i < CTRL_W; i++) begin
      r[i] = (c[i] === 1'b1);
    end
    return ctrl_t'(r);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector; a flush always wins over a stall.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_mem_read_i,
  input  logic [RW-1:0] ex_rt_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [5:0]    id_op_i,
  input  logic          flush_i,
  output logic          stall_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = uses_rt(id_op_i) && (ex_rt_i == id_rt_i);

  // $zero is never a real producer, so a load into it cannot create a hazard.
  assign stall_o = !flush_i && ex_mem_read_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush squashing.
// Optional ID_EX_PERF_CNT_EN adds a bubble_cnt performance counter output.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [5:0]        id_op,
  input  logic [DW-1:0]     id_pc4,
  input  logic [DW-1:0]     id_rs_data,
  input  logic [DW-1:0]     id_rt_data,
  input  logic [DW-1:0]     id_imm,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic [RW-1:0]     id_rd,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DW-1:0]     ex_pc4,
  output logic [DW-1:0]     ex_rs_data,
  output logic [DW-1:0]     ex_rt_data,
  output logic [DW-1:0]     ex_imm,
  output logic [RW-1:0]     ex_rs,
  output logic [RW-1:0]     ex_rt,
  output logic [RW-1:0]     ex_rd,
  output logic              stall
`ifdef ID_EX_PERF_CNT_EN
  , output logic [31:0]     bubble_cnt
`endif
);

  ctrl_t         ex_ctrl_q,    ex_ctrl_d;
  logic [DW-1:0] ex_pc4_q,     ex_pc4_d;
  logic [DW-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DW-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DW-1:0] ex_imm_q,     ex_imm_d;
  logic [RW-1:0] ex_rs_q,      ex_rs_d;
  logic [RW-1:0] ex_rt_q,      ex_rt_d;
  logic [RW-1:0] ex_rd_q,      ex_rd_d;
  logic          stall_w;
  logic          bubble;

  hazard_detect #(
    .RW (RW)
  ) u_hazard (
    .ex_mem_read_i (ex_ctrl_q.mem_read),
    .ex_rt_i       (ex_rt_q),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_op_i       (id_op),
    .flush_i       (flush),
    .stall_o       (stall_w)
  );

  assign bubble = flush || stall_w;

  always_comb begin
    ex_ctrl_d    = sanitize_ctrl(id_ctrl);
    ex_pc4_d     = id_pc4;
    ex_rs_data_d = id_rs_data;
    ex_rt_data_d = id_rt_data;
    ex_imm_d     = id_imm;
    ex_rs_d      = id_rs;
    ex_rt_d      = id_rt;
    ex_rd_d      = id_rd;
    if (bubble) begin
      ex_ctrl_d    = CTRL_BUBBLE;
      ex_pc4_d     = '0;
      ex_rs_data_d = '0;
      ex_rt_data_d = '0;
      ex_imm_d     = '0;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_rd_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Only hazard bubbles count; flush bubbles are a branch cost, not a load-use cost.
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_w && !flush) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign ex_ctrl    = ex_ctrl_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign stall      = stall_w;

endmodule
